// File: rtl/mod4051_serial_reducer.sv
// mod4051_serial_reducer: streams a base-64 operand (most significant chunk
// first) and produces operand mod MOD using Horner's rule. Each chunk folds
// into the running residue as t = r*64 + c. The sum is then reduced by
// conditional subtraction of MOD<<k for k = 5..0.
// Optional macro MOD4051_FAST_REDUCE_EN: perform all six subtractions in the
// accept cycle, so each chunk takes a single cycle.
module mod4051_serial_reducer #(
    parameter int MOD = 4051
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_chunk,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] out_residue
);

    typedef enum logic [1:0] {S_ACCEPT, S_REDUCE, S_DONE} state_e;

    localparam logic [17:0] MODW = 18'(MOD);

    state_e      state_q, state_d;
    logic [17:0] t_q, t_d;
    logic [2:0]  k_q, k_d;
    logic        last_q, last_d;
    logic [11:0] r_q, r_d;

    logic [17:0] t_acc;
    logic [17:0] t_step;

    // One restoring step: remove MOD<<k if it fits.
    function automatic logic [17:0] cond_sub(input logic [17:0] t, input logic [2:0] k);
        logic [17:0] m;
        m = MODW << k;
        return (t >= m) ? (t - m) : t;
    endfunction

`ifdef MOD4051_FAST_REDUCE_EN
    // Full six-step reduction. The input is below MOD*64, so the result is below MOD.
    function automatic logic [17:0] full_reduce(input logic [17:0] t);
        logic [17:0] v;
        v = t;
        for (int i = 5; i >= 0; i--) begin
            v = cond_sub(v, 3'(i));
        end
        return v;
    endfunction
`endif

    // Horner accumulate: r < MOD <= 4095, so r*64 + 63 always fits in 18 bits.
    assign t_acc  = {r_q, 6'b0} + {12'b0, in_chunk};
    assign t_step = cond_sub(t_q, k_q);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_ACCEPT;
            t_q     <= '0;
            k_q     <= 3'd5;
            last_q  <= 1'b0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            k_q     <= k_d;
            last_q  <= last_d;
            r_q     <= r_d;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        k_d     = k_q;
        last_d  = last_q;
        r_d     = r_q;
        case (state_q)
            S_ACCEPT: begin
                if (in_valid) begin
                    last_d = in_last;
`ifdef MOD4051_FAST_REDUCE_EN
                    r_d     = 12'(full_reduce(t_acc));
                    state_d = in_last ? S_DONE : S_ACCEPT;
`else
                    t_d     = t_acc;
                    k_d     = 3'd5;
                    state_d = S_REDUCE;
`endif
                end
            end
            S_REDUCE: begin
                t_d = t_step;
                if (k_q == 3'd0) begin
                    r_d     = t_step[11:0];
                    k_d     = 3'd5;
                    state_d = last_q ? S_DONE : S_ACCEPT;
                end else begin
                    k_d = k_q - 3'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    r_d     = '0;
                    last_d  = 1'b0;
                    state_d = S_ACCEPT;
                end
            end
            default: state_d = S_ACCEPT;
        endcase
    end

    // Handshake outputs. The residue is forced to zero when no result is held.
    always_comb begin
        in_ready    = (state_q == S_ACCEPT);
        out_valid   = (state_q == S_DONE);
        out_residue = (state_q == S_DONE) ? r_q : 12'd0;
    end

endmodule

// File: tb/tb_mod4051_serial_reducer.sv
// Bench for mod4051_serial_reducer. A reference model computes the full operand
// value with wide arithmetic and reduces it with %. A negedge monitor checks
// every result against a queue of expected residues.
module tb_mod4051_serial_reducer;

    localparam int MOD = 4051;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_chunk = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_residue;

    logic rdy_mode = 1'b0;
    logic man_ready = 1'b0;
    logic rnd_ready = 1'b0;
    assign out_ready = rdy_mode ? rnd_ready : man_ready;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    mod4051_serial_reducer #(.MOD(MOD)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_chunk(in_chunk), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_residue(out_residue)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #1;
        rnd_ready = 1'($urandom_range(0, 1));
    end

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Reference: build the whole operand value, then reduce it once.
    function automatic int ref_mod(input int ch[$]);
        logic [71:0] v;
        v = '0;
        foreach (ch[i]) v = v * 72'd64 + 72'(ch[i]);
        return int'(v % 72'(MOD));
    endfunction

    // Monitor: checks residue gating, results against expectations, and no input acceptance in DONE.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!out_valid) begin
                check("idle residue", int'(out_residue), 0);
            end else begin
                check("ready in done", int'(in_ready), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected result", 1, 0);
                end else begin
                    check("residue", int'(out_residue), exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Present one chunk and hold it until accepted. The task returns 1 time unit after the accepting edge.
    task automatic send_chunk(input int c, input bit last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_chunk = 6'(c);
        in_last  = last;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_chunk = 6'($urandom);
        in_last  = 1'($urandom);
    endtask

    task automatic send_operand(input int ch[$], input bit gaps);
        for (int i = 0; i < ch.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send_chunk(ch[i], i == ch.size() - 1);
        end
        exp_q.push_back(ref_mod(ch));
    endtask

    task automatic wait_result(input string nm, input int lit);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({nm, " valid"}, int'(out_valid), 1);
        check(nm, int'(out_residue), lit);
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string nm, input int ch[$], input int lit);
        check({nm, " model"}, ref_mod(ch), lit);
        send_operand(ch, 1'b0);
        wait_result(nm, lit);
    endtask

    initial begin
        int lat;
        int ch[$];
        // Asynchronous reset state before any clock edge.
        #2;
        check("reset in_ready", int'(in_ready), 1);
        check("reset out_valid", int'(out_valid), 0);
        check("reset residue", int'(out_residue), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        man_ready = 1'b1;

        // Single chunk: check the result and its latency.
        send_chunk(5, 1'b1);
        exp_q.push_back(5);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid) check("ready in reduce", int'(in_ready), 0);
        end while (!out_valid && lat < 50);
`ifdef MOD4051_FAST_REDUCE_EN
        check("latency", lat, 1);
`else
        check("latency", lat, 7);
`endif
        wait_result("single 5", 5);

        directed("4051", '{63, 19}, 0);
        directed("4095", '{63, 63}, 44);
        directed("4096", '{1, 0, 0}, 45);

        // Hold the result with out_ready low for 10 cycles.
        man_ready = 1'b0;
        send_operand('{63, 18}, 1'b0);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        for (int i = 0; i < 10; i++) begin
            check("hold residue", int'(out_residue), 4050);
            check("hold in_ready", int'(in_ready), 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        man_ready = 1'b1;
        @(negedge clk);
        check("handshake same-cycle in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        man_ready = 1'b0;
        @(negedge clk);
        check("next-cycle in_ready", int'(in_ready), 1);
        check("next-cycle out_valid", int'(out_valid), 0);
        man_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset during reduction of the second chunk of 1,0,0.
        send_chunk(1, 1'b0);
        send_chunk(0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid reset in_ready", int'(in_ready), 1);
        check("mid reset out_valid", int'(out_valid), 0);
        check("mid reset residue", int'(out_residue), 0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_chunk(7, 1'b1);
        exp_q.push_back(7);
        wait_result("after reset 7", 7);

        // Random operands with random input gaps and random back-pressure.
        rdy_mode = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            ch.delete();
            repeat ($urandom_range(1, 12)) ch.push_back(int'($urandom_range(0, 63)));
            send_operand(ch, 1'b1);
        end
        lat = 0;
        while (exp_q.size() != 0 && lat < 500) begin
            @(negedge clk);
            lat++;
        end
        check("drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
